vga_text_buffer: RTL and testbench

Parametrised character-cell video memory between the PS/2 keyboard front end and the VGA timing/font-ROM path. Accepts ASCII codes through a valid/ready handshake and maintains a cursor. Supports newline, backspace, line wrap and hardware scrolling through a circular top-row pointer. Serves the VGA scan with a registered character lookup plus glyph pixel offsets, and includes a sequenced clear engine and a blinking cursor indicator.

---
 rtl/vga_text_buffer.sv | 182 ++++++++++++++++++
 tb/tb_vga_text_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_buffer.sv
// Character-cell text buffer: keyboard writes through a cursor/scroll FSM,
// VGA scan reads a registered character plus glyph pixel offsets.
module vga_text_buffer #(
  parameter int COLS         = 70,
  parameter int ROWS         = 30,
  parameter int CHAR_W       = 9,
  parameter int CHAR_H       = 16,
  parameter int BLINK_CYCLES = 25000000,
  parameter int XW           = $clog2(COLS),
  parameter int YW           = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    key_in,
  input  logic          key_valid,
  output logic          key_ready,
  input  logic [9:0]    h_addr,
  input  logic [9:0]    v_addr,
  output logic [7:0]    ascii_out,
  output logic [3:0]    glyph_row,
  output logic [3:0]    glyph_col,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          cursor_on
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int BW    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, SCROLL_CLR} state_t;
  state_t state, state_n;

  logic [7:0]    mem [CELLS];
  logic [XW-1:0] x_n;
  logic [YW-1:0] y_n, top_row, top_n;
  logic [AW-1:0] clr_ptr, clr_n, waddr, raddr, cur_addr;
  logic [7:0]    wdata;
  logic          we, do_nl;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [9:0]    scan_col, scan_row;
  logic [3:0]    scan_gcol, scan_grow;
  logic          scan_hit;

  // Logical row is rotated by the circular top-row pointer, modulo ROWS.
  function automatic logic [AW-1:0] phys(input logic [YW-1:0] top,
                                         input logic [YW-1:0] row,
                                         input logic [XW-1:0] col);
    logic [YW:0] s;
    s = {1'b0, top} + {1'b0, row};
    if (s >= (YW+1)'(ROWS)) s = s - (YW+1)'(ROWS);
    return AW'(s) * AW'(COLS) + AW'(col);
  endfunction

  assign cur_addr = phys(top_row, cursor_y, cursor_x);

  always_comb begin
    state_n = state;
    x_n     = cursor_x;
    y_n     = cursor_y;
    top_n   = top_row;
    clr_n   = clr_ptr;
    we      = 1'b0;
    waddr   = cur_addr;
    wdata   = '0;
    do_nl   = 1'b0;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_ptr;
        clr_n = clr_ptr + 1'b1;
        if (clr_ptr == AW'(CELLS - 1)) begin
          state_n = IDLE;
          clr_n   = '0;
        end
      end
      SCROLL_CLR: begin
        we    = 1'b1;
        waddr = phys(top_row, Y_LAST, XW'(clr_ptr));
        clr_n = clr_ptr + 1'b1;
        if (clr_ptr == AW'(COLS - 1)) begin
          state_n = IDLE;
          clr_n   = '0;
        end
      end
      default: begin
        if (key_valid && key_ready) begin
          if (key_in >= 8'h20 && key_in <= 8'h7e) begin
            we    = 1'b1;
            wdata = key_in;
            if (cursor_x == X_LAST) do_nl = 1'b1;
            else x_n = cursor_x + 1'b1;
          end else if (key_in == 8'h0a || key_in == 8'h0d) begin
            do_nl = 1'b1;
          end else if (key_in == 8'h08) begin
            if (cursor_x != '0) begin
              x_n   = cursor_x - 1'b1;
              we    = 1'b1;
              waddr = phys(top_row, cursor_y, x_n);
            end else if (cursor_y != '0) begin
              x_n   = X_LAST;
              y_n   = cursor_y - 1'b1;
              we    = 1'b1;
              waddr = phys(top_row, y_n, X_LAST);
            end
          end
        end
        // Newline also follows a printable written in the last column.
        if (do_nl) begin
          x_n = '0;
          if (cursor_y != Y_LAST) begin
            y_n = cursor_y + 1'b1;
          end else begin
            top_n   = (top_row == Y_LAST) ? '0 : top_row + 1'b1;
            state_n = SCROLL_CLR;
            clr_n   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clr_ptr   <= '0;
      cursor_x  <= '0;
      cursor_y  <= '0;
      top_row   <= '0;
      key_ready <= 1'b0;
    end else begin
      state     <= state_n;
      clr_ptr   <= clr_n;
      cursor_x  <= x_n;
      cursor_y  <= y_n;
      top_row   <= top_n;
      key_ready <= (state_n == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr] <= wdata;
  end

  assign scan_col  = h_addr / 10'(CHAR_W);
  assign scan_row  = v_addr / 10'(CHAR_H);
  assign scan_gcol = 4'(h_addr - scan_col * 10'(CHAR_W));
  assign scan_grow = 4'(v_addr % 10'(CHAR_H));
  assign scan_hit  = (scan_col < 10'(COLS)) && (scan_row < 10'(ROWS));
  assign raddr     = phys(top_row, YW'(scan_row), XW'(scan_col));

  // Reading mem here with a separate write block gives read-before-write.
  always_ff @(posedge clk) begin
    if (reset) begin
      ascii_out <= '0;
      glyph_row <= '0;
      glyph_col <= '0;
    end else begin
      ascii_out <= scan_hit ? mem[raddr] : '0;
      glyph_row <= scan_grow;
      glyph_col <= scan_gcol;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign cursor_on = blink_phase && (state == IDLE);

endmodule

// File: tb/tb_vga_text_buffer.sv
// Scoreboard bench for vga_text_buffer: a logical-screen model predicts cursor,
// handshake, blink and scan reads; a monitor compares every cycle.
module tb_vga_text_buffer;
  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CW    = 9;
  localparam int CH    = 16;
  localparam int B     = 37;
  localparam int CELLS = COLS * ROWS;
  localparam int XW    = $clog2(COLS);
  localparam int YW    = $clog2(ROWS);

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    key_in;
  logic          key_valid;
  logic          key_ready;
  logic [9:0]    h_addr, v_addr;
  logic [7:0]    ascii_out;
  logic [3:0]    glyph_row, glyph_col;
  logic [XW-1:0] cursor_x;
  logic [YW-1:0] cursor_y;
  logic          cursor_on;

  vga_text_buffer #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_W(CW), .CHAR_H(CH), .BLINK_CYCLES(B)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .h_addr(h_addr), .v_addr(v_addr),
    .ascii_out(ascii_out), .glyph_row(glyph_row), .glyph_col(glyph_col),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_on(cursor_on)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: the screen as seen by the viewer, line 0 at the top.
  logic [7:0]  scr [ROWS][COLS];
  int          cx, cy, busy, ecnt;
  logic        probe_v;
  logic        pv;
  logic [15:0] exp_q [$];
  logic [15:0] exp_e;

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h00;
    cx = 0; cy = 0; busy = CELLS; ecnt = 0;
  endtask

  task automatic model_newline();
    cx = 0;
    if (cy < ROWS - 1) cy++;
    else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h00;
      busy = COLS;
    end
  endtask

  task automatic model_key(input logic [7:0] k);
    if (k >= 8'h20 && k <= 8'h7e) begin
      scr[cy][cx] = k;
      if (cx == COLS - 1) model_newline();
      else cx++;
    end else if (k == 8'h0a || k == 8'h0d) begin
      model_newline();
    end else if (k == 8'h08) begin
      if (cx > 0) begin
        cx--; scr[cy][cx] = 8'h00;
      end else if (cy > 0) begin
        cy--; cx = COLS - 1; scr[cy][cx] = 8'h00;
      end
    end
  endtask

  always @(posedge clk) begin
    pv = probe_v;
    if (reset) model_reset();
    else begin
      ecnt++;
      if (busy > 0) busy--;
      else if (key_valid) model_key(key_in);
    end
    #1;
    check("key_ready", int'(key_ready), int'(busy == 0));
    check("cursor_x", int'(cursor_x), cx);
    check("cursor_y", int'(cursor_y), cy);
    check("cursor_on", int'(cursor_on), int'((((ecnt / B) % 2) == 1) && busy == 0));
    if (pv) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL read_queue actual=empty expected=entry");
      end else begin
        exp_e = exp_q.pop_front();
        check("ascii_out", int'(ascii_out), int'(exp_e[15:8]));
        check("glyph_row", int'(glyph_row), int'(exp_e[7:4]));
        check("glyph_col", int'(glyph_col), int'(exp_e[3:0]));
      end
    end
  end

  task automatic push_expected(input int h, input int v);
    int col, row;
    logic [7:0] a;
    col = h / CW;
    row = v / CH;
    a = (col < COLS && row < ROWS) ? scr[row][col] : 8'h00;
    exp_q.push_back({a, 4'(v % CH), 4'(h % CW)});
    h_addr  = 10'(h);
    v_addr  = 10'(v);
    probe_v = 1'b1;
  endtask

  task automatic probe(input int h, input int v);
    push_expected(h, v);
    @(negedge clk);
    probe_v = 1'b0;
  endtask

  task automatic scan_all();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        push_expected(c * CW + $urandom_range(0, CW - 1), r * CH + $urandom_range(0, CH - 1));
        @(negedge clk);
      end
    probe_v = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy != 0 && n < CELLS + 200) begin
      @(negedge clk);
      n++;
    end
    if (busy != 0) begin
      checks++; errors++;
      $display("FAIL wait_ready actual=busy expected=ready");
    end
  endtask

  task automatic send_key(input logic [7:0] k);
    wait_ready();
    key_in = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(32, 126));
  endfunction

  int cyc, r;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_in = '0;
    h_addr = '0; v_addr = '0; probe_v = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cyc = 1;
    while (!key_ready && cyc < CELLS + 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_rise_cycle", cyc, CELLS + 1);
    scan_all();

    send_key(8'h41); send_key(8'h42);
    check("ab_cursor_x", int'(cursor_x), 2);
    check("ab_cursor_y", int'(cursor_y), 0);
    probe(9, 5);
    check("ab_ascii", int'(ascii_out), 8'h42);
    check("ab_grow", int'(glyph_row), 5);
    check("ab_gcol", int'(glyph_col), 0);
    probe(13, 5);
    check("gcol_4", int'(glyph_col), 4);

    send_key(8'h08); send_key(8'h08);
    repeat (COLS) send_key(rand_print());
    send_key(8'h5a);
    check("wrap_cursor_x", int'(cursor_x), 1);
    check("wrap_cursor_y", int'(cursor_y), 1);
    probe(0, CH);
    check("wrap_z", int'(ascii_out), 8'h5a);
    send_key(8'h08); send_key(8'h08);
    check("bs_cursor_x", int'(cursor_x), COLS - 1);
    check("bs_cursor_y", int'(cursor_y), 0);
    probe((COLS - 1) * CW, 0);
    check("bs_cell", int'(ascii_out), 0);

    repeat (COLS - 1) send_key(8'h08);
    send_key(8'h08);
    check("bs00_x", int'(cursor_x), 0);
    check("bs00_y", int'(cursor_y), 0);
    send_key(8'h1b);
    check("esc_x", int'(cursor_x), 0);
    probe(630, 0);
    check("col70_ascii", int'(ascii_out), 0);

    for (int row = 0; row < ROWS - 1; row++) begin
      if (row == 1) begin
        send_key(8'h48); send_key(8'h49);
      end else repeat ($urandom_range(0, 8)) send_key(rand_print());
      send_key(8'h0a);
    end
    check("fill_y", int'(cursor_y), ROWS - 1);
    repeat (3) send_key(rand_print());
    send_key(8'h0a);
    cyc = 0;
    while (!key_ready && cyc < 200) begin
      key_valid = (cyc == 10);
      key_in = 8'h58;
      @(negedge clk);
      cyc++;
    end
    key_valid = 1'b0;
    check("scroll_stall", cyc, COLS);
    check("scroll_cursor_y", int'(cursor_y), ROWS - 1);
    probe(0, 0);
    check("scroll_row0_h", int'(ascii_out), 8'h48);
    probe(CW, 3);
    check("scroll_row0_i", int'(ascii_out), 8'h49);
    probe(5 * CW, (ROWS - 1) * CH);
    check("scroll_bottom", int'(ascii_out), 0);
    for (int c = 0; c < COLS; c++) probe(c * CW, 7);
    for (int c = 0; c < COLS; c++) probe(c * CW + 2, (ROWS - 1) * CH + 9);

    repeat (COLS) send_key(rand_print());
    wait_ready();
    check("edge_scroll_x", int'(cursor_x), 0);
    check("edge_scroll_y", int'(cursor_y), ROWS - 1);
    for (int c = 0; c < COLS; c++) probe(c * CW, (ROWS - 2) * CH);

    repeat (1500) begin
      r = $urandom_range(0, 99);
      key_valid = ($urandom_range(0, 3) != 0);
      if (r < 60) key_in = rand_print();
      else if (r < 72) key_in = 8'h0a;
      else if (r < 75) key_in = 8'h0d;
      else if (r < 90) key_in = 8'h08;
      else key_in = 8'($urandom_range(0, 255));
      if (busy == 0 && $urandom_range(0, 1) == 1)
        push_expected($urandom_range(0, (COLS + 3) * CW), $urandom_range(0, (ROWS + 2) * CH - 1));
      else probe_v = 1'b0;
      @(negedge clk);
    end
    key_valid = 1'b0;
    probe_v = 1'b0;

    wait_ready();
    for (int i = 0; i < ROWS && cy < ROWS - 1; i++) send_key(8'h0a);
    send_key(8'h0a);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_cursor_x", int'(cursor_x), 0);
    check("rst_cursor_y", int'(cursor_y), 0);
    check("rst_cursor_on", int'(cursor_on), 0);
    check("rst_key_ready", int'(key_ready), 0);
    wait_ready();
    scan_all();
    send_key(8'h54);
    probe(0, 0);
    check("post_rst_t", int'(ascii_out), 8'h54);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
